// File: rtl/aes_cipher_arbiter.sv
// Two-requester round-robin scheduler in front of one iterative AES core.
// The core has no start/done, so it is sequenced by holding it in reset and releasing it for CORE_LATENCY clocks.
module aes_cipher_arbiter #(
  parameter  int NK = 4,
  parameter  int NR = 10,
  localparam int KW = NK * 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [127:0]  req0_data,
  input  logic [KW-1:0] req0_key,
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic [127:0]  resp0_data,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [127:0]  req1_data,
  input  logic [KW-1:0] req1_key,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [127:0]  resp1_data,

  output logic          core_rst,
  output logic [127:0]  core_data_in,
  output logic [KW-1:0] core_key,
  input  logic [127:0]  core_data_out,

  output logic          busy
);

  localparam int CORE_LATENCY = 4 * NR;
  localparam int CNT_W        = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic            owner;
  logic            last_grant;
  logic [127:0]    data_q;
  logic [KW-1:0]   key_q;

  logic            grant_vld;
  logic            grant_sel;
  logic            accept;
  logic            run_done;
  logic            resp_hs;

  // Grant only exists in IDLE; a tie goes to the port that was not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (state == IDLE) begin
      unique case ({req1_valid, req0_valid})
        2'b01: begin
          grant_vld = 1'b1;
          grant_sel = 1'b0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_sel = ~last_grant;
        end
        default: begin
          grant_vld = 1'b0;
          grant_sel = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant_vld & ~grant_sel;
  assign req1_ready = grant_vld &  grant_sel;

  // Every grant is a handshake: the granted port is by construction valid.
  assign accept   = grant_vld;
  assign run_done = (state == RUN) && (cnt == CNT_W'(CORE_LATENCY));
  assign resp_hs  = (state == RESP) && (owner ? resp1_ready : resp0_ready);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (run_done) state_nxt = RESP;
      RESP:    if (resp_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst    <= 1'b1;
      cnt         <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      data_q      <= '0;
      key_q       <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_data  <= '0;
      resp1_data  <= '0;
    end else begin
      if (accept) begin
        data_q     <= grant_sel ? req1_data : req0_data;
        key_q      <= grant_sel ? req1_key  : req0_key;
        owner      <= grant_sel;
        last_grant <= grant_sel;
        cnt        <= '0;
        core_rst   <= 1'b0;
      end else if (state == RUN) begin
        // Counter parks at CORE_LATENCY on the exit cycle, so it can never wrap.
        if (run_done) begin
          core_rst <= 1'b1;
          if (owner) begin
            resp1_data  <= core_data_out;
            resp1_valid <= 1'b1;
          end else begin
            resp0_data  <= core_data_out;
            resp0_valid <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (resp_hs) begin
        resp0_valid <= 1'b0;
        resp1_valid <= 1'b0;
      end
    end
  end

  assign core_data_in = data_q;
  assign core_key     = key_q;
  assign busy         = (state != IDLE);

  a_one_ready : assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  a_core_run : assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> !core_rst);

  a_resp0_hold : assert property (@(posedge clk) disable iff (rst)
    (resp0_valid && !resp0_ready) |=> (resp0_valid && $stable(resp0_data)));

  a_resp1_hold : assert property (@(posedge clk) disable iff (rst)
    (resp1_valid && !resp1_ready) |=> (resp1_valid && $stable(resp1_data)));

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// Bench for aes_cipher_arbiter: behavioural AES core, a transaction-level arbiter model, directed scenarios and random traffic.
module tb_aes_cipher_arbiter;

  localparam int NK = 4;
  localparam int NR = 10;
  localparam int KW = NK * 32;
  localparam int CL = 4 * NR;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic          req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [127:0]  req0_data, req1_data, resp0_data, resp1_data;
  logic [KW-1:0] req0_key, req1_key;
  logic          core_rst;
  logic [127:0]  core_data_in, core_data_out;
  logic [KW-1:0] core_key;
  logic          busy;

  aes_cipher_arbiter #(.NK(NK), .NR(NR)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .core_rst(core_rst), .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- AES reference ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [KW-1:0] key);
    logic [31:0]  w [4*(NR+1)];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4*(NR+1); i++) begin
      if (i < NK) w[i] = key[KW-1-32*i -: 32];
      else begin
        tmp = w[i-1];
        if (i % NK == 0) begin
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
          rc  = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          tmp = sub_word(tmp);
        end
        w[i] = w[i-NK] ^ tmp;
      end
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sbox_t[s[j]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
      if (r != NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = t[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // ---------------- Behavioural core: valid only after CL clocks out of reset ----------------
  int unsigned core_cnt = 0;
  always @(posedge clk) begin
    if (core_rst)          core_cnt <= 0;
    else if (core_cnt < 1000) core_cnt <= core_cnt + 1;
  end
  always @(negedge clk) begin
    if (core_cnt >= CL) core_data_out = aes_enc(core_data_in, core_key);
    else                core_data_out = core_data_in ^ {4{32'h5a5aa5a5}};
  end

  // ---------------- Stimulus state ----------------
  logic [127:0]  pt0, pt1;
  logic [KW-1:0] key0, key1;
  logic          pend0 = 1'b0, pend1 = 1'b0;
  logic          rr0 = 1'b0, rr1 = 1'b0;
  logic          rst_drive = 1'b1;

  // ---------------- Transaction model ----------------
  bit            m_busy = 1'b0;
  int            m_age  = 0;
  bit            m_owner = 1'b0;
  bit            m_last  = 1'b1;
  logic [127:0]  m_pt  = '0;
  logic [KW-1:0] m_key = '0;
  logic [127:0]  m_resp_data [2];

  int            acc_port [$];
  int            acc_edge [$];
  int            resp_port [$];
  int            resp_edge [$];
  logic [127:0]  resp_dlog [$];
  int            rise_edge [2];
  int            rise_cnt  [2];
  bit            prv       [2];

  task automatic new_vec(input int p);
    logic [127:0]  d;
    logic [KW-1:0] k;
    d = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NK; i++) k[32*i +: 32] = $urandom;
    if (p == 0) begin pt0 = d; key0 = k; end
    else        begin pt1 = d; key1 = k; end
  endtask

  task automatic tick();
    bit gv, gs, evr, rhs, hs0, hs1, rh0, rh1;
    logic [127:0] rd0, rd1;
    @(negedge clk);
    rst         = rst_drive;
    req0_valid  = pend0;  req0_data = pt0;  req0_key = key0;
    req1_valid  = pend1;  req1_data = pt1;  req1_key = key1;
    resp0_ready = rr0;
    resp1_ready = rr1;
    #1;
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_pt = '0; m_key = '0;
      m_resp_data[0] = '0; m_resp_data[1] = '0;
    end
    gv = 1'b0; gs = 1'b0;
    if (!rst && !m_busy) begin
      if (req0_valid && req1_valid) begin gv = 1'b1; gs = !m_last; end
      else if (req0_valid)          begin gv = 1'b1; gs = 1'b0; end
      else if (req1_valid)          begin gv = 1'b1; gs = 1'b1; end
    end
    evr = !rst && m_busy && (m_age > CL);
    if (!rst) begin
      check_eq("req0_ready", req0_ready, gv && !gs);
      check_eq("req1_ready", req1_ready, gv && gs);
    end
    check_eq("resp0_valid", resp0_valid, evr && !m_owner);
    check_eq("resp1_valid", resp1_valid, evr && m_owner);
    check_eq("resp0_data", resp0_data, m_resp_data[0]);
    check_eq("resp1_data", resp1_data, m_resp_data[1]);
    check_eq("busy", busy, m_busy);
    check_eq("core_rst", core_rst, !(m_busy && m_age <= CL));
    check_eq("core_data_in", core_data_in, m_pt);
    check_eq("core_key", core_key, m_key);
    hs0 = !rst && req0_valid && req0_ready;
    hs1 = !rst && req1_valid && req1_ready;
    rh0 = resp0_valid && resp0_ready;
    rh1 = resp1_valid && resp1_ready;
    rd0 = resp0_data;
    rd1 = resp1_data;
    if (resp0_valid && !prv[0]) begin rise_edge[0] = cyc; rise_cnt[0]++; end
    if (resp1_valid && !prv[1]) begin rise_edge[1] = cyc; rise_cnt[1]++; end
    prv[0] = resp0_valid;
    prv[1] = resp1_valid;
    rhs = evr && (m_owner ? resp1_ready : resp0_ready);
    @(posedge clk);
    cyc++;
    if (hs0) begin acc_port.push_back(0); acc_edge.push_back(cyc); pend0 = 1'b0; end
    if (hs1) begin acc_port.push_back(1); acc_edge.push_back(cyc); pend1 = 1'b0; end
    if (rh0) begin resp_port.push_back(0); resp_edge.push_back(cyc); resp_dlog.push_back(rd0); end
    if (rh1) begin resp_port.push_back(1); resp_edge.push_back(cyc); resp_dlog.push_back(rd1); end
    if (!rst) begin
      if (gv) begin
        m_busy = 1'b1; m_age = 0; m_owner = gs; m_last = gs;
        m_pt  = gs ? req1_data : req0_data;
        m_key = gs ? req1_key  : req0_key;
      end else if (m_busy) begin
        if (rhs) m_busy = 1'b0;
        else if (m_age <= CL) begin
          if (m_age == CL) m_resp_data[m_owner] = aes_enc(m_pt, m_key);
          m_age++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_drive = 1'b1;
    tick();
    tick();
    rst_drive = 1'b0;
    tick();
  endtask

  task automatic run_accepts(input string tag, input int n, input int bound);
    for (int k = 0; k < bound && acc_port.size() < n; k++) tick();
    check_eq(tag, acc_port.size(), n);
  endtask

  task automatic wait_resp(input string tag, input int n, input int bound);
    for (int k = 0; k < bound && resp_port.size() < n; k++) tick();
    check_eq(tag, resp_port.size(), n);
  endtask

  task automatic wait_rise(input string tag, input int p, input int n, input int bound);
    for (int k = 0; k < bound && rise_cnt[p] < n; k++) tick();
    check_eq(tag, rise_cnt[p], n);
  endtask

  function automatic int count_port0();
    int c;
    c = 0;
    foreach (acc_port[i]) if (acc_port[i] == 0) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int na, nr, n0, r0;
    m_resp_data[0] = '0; m_resp_data[1] = '0;
    rise_edge[0] = 0; rise_edge[1] = 0; rise_cnt[0] = 0; rise_cnt[1] = 0;
    prv[0] = 1'b0; prv[1] = 1'b0;
    pt0 = '0; pt1 = '0; key0 = '0; key1 = '0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, inv;
      x = i[7:0];
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gmul(x, j[7:0]) == 8'h01) inv = j[7:0];
      sbox_t[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    // Reset state, then FIPS-197 vector on port 0.
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1;
    key0 = 128'h000102030405060708090a0b0c0d0e0f;
    pt0  = 128'h00112233445566778899aabbccddeeff;
    pend0 = 1'b1;
    na = acc_port.size(); nr = resp_port.size();
    run_accepts("s1_accept", na + 1, 10);
    wait_resp("s1_resp", nr + 1, 60);
    if (acc_port.size() > na && resp_port.size() > nr) begin
      check_eq("s1_port", acc_port[na], 0);
      check_eq("s1_latency", rise_edge[0] - acc_edge[na], 41);
      check_eq("s1_resp_port", resp_port[nr], 0);
      check_eq("s1_data", resp_dlog[nr], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    end
    check_eq("s1_resp1_rises", rise_cnt[1], 0);

    // Port 1 alone, FIPS-197 appendix B vector.
    key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pt1  = 128'h3243f6a8885a308d313198a2e0370734;
    pend1 = 1'b1;
    na = acc_port.size(); nr = resp_port.size();
    run_accepts("s2_accept", na + 1, 10);
    wait_resp("s2_resp", nr + 1, 60);
    if (acc_port.size() > na && resp_port.size() > nr) begin
      check_eq("s2_port", acc_port[na], 1);
      check_eq("s2_latency", rise_edge[1] - acc_edge[na], 41);
      check_eq("s2_data", resp_dlog[nr], 128'h3925841d02dc09fbdc118597196a0b32);
    end

    // Both ports valid continuously: strict alternation at the minimum period.
    do_reset();
    new_vec(0); new_vec(1);
    pend0 = 1'b1; pend1 = 1'b1;
    na = acc_port.size();
    for (int k = 0; k < 300 && acc_port.size() < na + 4; k++) begin
      tick();
      if (!pend0) begin new_vec(0); pend0 = 1'b1; end
      if (!pend1) begin new_vec(1); pend1 = 1'b1; end
    end
    pend0 = 1'b0; pend1 = 1'b0;
    check_eq("s3_accepts", acc_port.size(), na + 4);
    if (acc_port.size() >= na + 4) begin
      for (int k = 0; k < 4; k++) check_eq("s3_order", acc_port[na+k], k % 2);
      for (int k = 1; k < 4; k++) check_eq("s3_spacing", acc_edge[na+k] - acc_edge[na+k-1], 43);
    end
    nr = resp_port.size();
    wait_resp("s3_drain", nr + 1, 60);

    // Back-pressure on port 0 while port 1 waits.
    new_vec(0);
    pend0 = 1'b1; rr0 = 1'b0;
    r0 = rise_cnt[0];
    wait_rise("s4_rise", 0, r0 + 1, 80);
    new_vec(1);
    pend1 = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rr0 = 1'b1;
    na = acc_port.size(); nr = resp_port.size();
    run_accepts("s4_accept1", na + 1, 10);
    if (acc_port.size() > na && resp_port.size() > nr) begin
      check_eq("s4_port", acc_port[na], 1);
      check_eq("s4_accept_after_hs", acc_edge[na] - resp_edge[nr], 1);
    end
    wait_resp("s4_drain", nr + 2, 60);

    // Reset 20 cycles into a run: block dropped, tie afterwards goes to port 0.
    do_reset();
    new_vec(0);
    pend0 = 1'b1;
    na = acc_port.size();
    run_accepts("s5_accept", na + 1, 10);
    for (int k = 0; k < 20; k++) tick();
    nr = resp_port.size();
    rst_drive = 1'b1;
    tick();
    rst_drive = 1'b0;
    new_vec(0); new_vec(1);
    pend0 = 1'b1; pend1 = 1'b1;
    rr1 = 1'b0;
    na = acc_port.size();
    run_accepts("s5_accept2", na + 1, 10);
    check_eq("s5_no_resp", resp_port.size(), nr);
    wait_resp("s5_resp", nr + 1, 60);
    if (acc_port.size() > na && resp_port.size() > nr) begin
      check_eq("s5_tie_port", acc_port[na], 0);
      check_eq("s5_latency", rise_edge[0] - acc_edge[na], 41);
    end

    // Port 1 block held in RESP; port 0 withdraws once IDLE returns.
    run_accepts("s6_accept1", na + 2, 10);
    r0 = rise_cnt[1];
    wait_rise("s6_rise", 1, r0 + 1, 80);
    new_vec(0); new_vec(1);
    pend0 = 1'b1; pend1 = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    n0 = count_port0();
    na = acc_port.size(); nr = resp_port.size();
    rr1 = 1'b1;
    tick();
    pend0 = 1'b0;
    tick();
    check_eq("s6_accept", acc_port.size(), na + 1);
    if (acc_port.size() > na && resp_port.size() > nr) begin
      check_eq("s6_port", acc_port[na], 1);
      check_eq("s6_same_cycle", acc_edge[na] - resp_edge[nr], 1);
    end
    wait_resp("s6_resp", nr + 2, 60);
    check_eq("s6_port0_never", count_port0(), n0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (!pend0 && $urandom_range(0, 7) == 0) begin new_vec(0); pend0 = 1'b1; end
      else if (pend0 && $urandom_range(0, 63) == 0) pend0 = 1'b0;
      if (!pend1 && $urandom_range(0, 7) == 0) begin new_vec(1); pend1 = 1'b1; end
      else if (pend1 && $urandom_range(0, 63) == 0) pend1 = 1'b0;
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      rst_drive = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst_drive = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0;
    rr0 = 1'b1; rr1 = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    check_eq("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_cipher_arbiter.md
Name: aes_cipher_arbiter

Overview:
Two-requester scheduler that shares one iterative AES cipher core (4 cycles per round, no start/done) between two independent clients. It accepts a plaintext/key pair from one requester at a time over a valid/ready handshake, sequences the core by holding it in reset and then releasing it for a fixed number of cycles, and captures the ciphertext. It returns the result to the owning requester over a valid/ready response channel. Ties are resolved round-robin. The block sits between the client-side bus adapters and the single cipher instance.

Parameters:
NK, 4, key length in 32-bit words; key width KW = NK*32.
NR, 10, number of cipher rounds; must match the attached core.
CORE_LATENCY, 4*NR (derived localparam, 40 by default), core clocks from reset release to valid core_data_out.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has a block to encrypt
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_data  in  128  requester 0 plaintext
req0_key  in  KW  requester 0 cipher key
resp0_valid  out  1  ciphertext for requester 0 available
resp0_ready  in  1  requester 0 consumes the response
resp0_data  out  128  ciphertext for requester 0
req1_valid, req1_ready, req1_data, req1_key, resp1_valid, resp1_ready, resp1_data: same as port 0, for requester 1
core_rst  out  1  reset to the cipher core (registered)
core_data_in  out  128  plaintext to the core
core_key  out  KW  key to the core
core_data_out  in  128  ciphertext from the core
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async): state=IDLE; core_rst=1; resp0_valid=resp1_valid=0; resp*_data=0; captured data/key=0; cnt=0; owner=0; last_grant=1, so port 0 wins the first tie.
- Grant (combinational, IDLE only): only one valid -> that port; both valid -> port != last_grant; neither -> none.
- reqN_ready = (state==IDLE) && grant==N. It is never high in RUN or RESP. Both readies are never high together.
- IDLE: core_rst=1. On handshake (reqN_valid && reqN_ready): capture data/key into internal regs, owner=N, last_grant=N, cnt=0, core_rst<=0, state->RUN.
- A requester may drop valid before its handshake. Grant is re-evaluated every IDLE cycle and no request is lost or duplicated.
- RUN: core_data_in/core_key driven from the captured regs, stable for the whole run. core_rst=0. cnt increments every cycle.
- RUN exit: when cnt==CORE_LATENCY: respOwner_data<=core_data_out, respOwner_valid<=1, core_rst<=1, state->RESP.
- Latency: resp_valid rises CORE_LATENCY+1 clocks after the accept edge (41 by default).
- RESP: respOwner_valid held high and data held stable until respOwner_ready. Core remains in reset.
- On the response handshake: resp_valid<=0, state->IDLE. The next accept happens at the earliest on the following cycle. Minimum period is CORE_LATENCY+3 clocks per block.
- The non-owner response port stays valid=0, and its data register is unchanged.
- rst asserted mid-RUN or mid-RESP: in-flight block is discarded, no response is issued, core_rst=1 immediately, and last_grant returns to 1.
- core_data_in/core_key outside RUN: hold the last captured values. Don't-care to the core, which is held in reset.
- cnt width: clog2(CORE_LATENCY+1) bits. cnt never wraps, because the exit condition is checked before overflow.

Test Plan:
- Single request, port 0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> resp0_valid exactly 41 clocks after the accept edge, resp0_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp1_valid stays 0.
- Port 1 alone, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> resp1_data=3925841d02dc09fbdc118597196a0b32, req0_ready=0 throughout.
- Both valid continuously with distinct vectors, after reset -> service order 0,1,0,1; each response correct; accepts spaced ≥43 clocks.
- Back-pressure: resp0_ready low for 10 cycles after resp0_valid -> data stable, core_rst=1, req1_ready=0 until the handshake; port 1 is accepted on the cycle after the handshake.
- rst pulse at cycle 20 of RUN -> no resp_valid; next request completes with correct ciphertext and 41-clock latency; a tie goes to port 0.
- req0_valid withdrawn while req1 is pending in IDLE -> port 1 granted that cycle; port 0 is never acknowledged.
